qthree_sweep_gen: RTL and testbench

Operand sequencer that sits directly upstream of the 4-bit `qthree` ALU. It drives the ALU's `a`, `b` and `select` inputs through every combination in a configured range and holds each vector for a programmable number of cycles. On the last cycle of each hold window it samples the ALU's 5-bit result into a running sum and a vector count. Software or a bench uses it to exercise the ALU exhaustively in hardware and read back a single checksum.

---
 rtl/qthree_sweep_gen.sv | 124 ++++++++++++
 tb/tb_qthree_sweep_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/qthree_sweep_gen.sv
// ============================================================================
// Module   : qthree_sweep_gen
// Purpose  : Sweeps (a, b, select) across a configured range for the qthree
//            ALU. Each vector is held for HOLD_CYCLES cycles, and the ALU result
//            is accumulated into a checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qthree_sweep_gen #(
    parameter int HOLD_CYCLES = 20,
    parameter int A_FIRST     = 1,
    parameter int A_LAST      = 3,
    parameter int B_FIRST     = 1,
    parameter int B_LAST      = 3,
    parameter int SEL_LAST    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  alu_out,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic [2:0]  select,
    output logic        vec_valid,
    output logic        busy,
    output logic        done,
    output logic [11:0] vec_count,
    output logic [15:0] checksum
);

    localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] C_A_FIRST   = 4'(A_FIRST);
    localparam logic [3:0] C_A_LAST    = 4'(A_LAST);
    localparam logic [3:0] C_B_FIRST   = 4'(B_FIRST);
    localparam logic [3:0] C_B_LAST    = 4'(B_LAST);
    localparam logic [2:0] C_SEL_LAST  = 3'(SEL_LAST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 8'd0;
            a          <= 4'd0;
            b          <= 4'd0;
            select     <= 3'd0;
            vec_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vec_count  <= 12'd0;
            checksum   <= 16'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state    <= S_RUN;
                        r_hold_cnt <= 8'd0;
                        a          <= C_A_FIRST;
                        b          <= C_B_FIRST;
                        select     <= 3'd0;
                        vec_valid  <= 1'b1;
                        busy       <= 1'b1;
                        vec_count  <= 12'd0;
                        checksum   <= 16'd0;
                    end
                end

                S_RUN: begin
                    // Abort wins even on a sample edge: partial totals stay as-is.
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_hold_cnt <= 8'd0;
                        vec_valid  <= 1'b0;
                        busy       <= 1'b0;
                    end else if (r_hold_cnt == C_HOLD_LAST) begin
                        r_hold_cnt <= 8'd0;
                        checksum   <= checksum + {11'd0, alu_out};
                        vec_count  <= vec_count + 12'd1;
                        if (b != C_B_LAST) begin
                            b <= b + 4'd1;
                        end else if (a != C_A_LAST) begin
                            b <= C_B_FIRST;
                            a <= a + 4'd1;
                        end else if (select != C_SEL_LAST) begin
                            b      <= C_B_FIRST;
                            a      <= C_A_FIRST;
                            select <= select + 3'd1;
                        end else begin
                            r_state   <= S_DONE;
                            vec_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state   <= S_IDLE;
                    vec_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qthree_sweep_gen.sv
// ============================================================================
// Module   : tb_qthree_sweep_gen
// Purpose  : Directed self-checking bench for qthree_sweep_gen (three configs)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qthree_sweep_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // dut0: HOLD=2, defaults; stub is a+b or constant 1
    logic        start0 = 0, abort0 = 0, mode0 = 0;
    logic [4:0]  alu0;
    logic [3:0]  a0, b0;
    logic [2:0]  sel0;
    logic        vv0, busy0, done0;
    logic [11:0] cnt0;
    logic [15:0] sum0;
    assign alu0 = mode0 ? 5'd1 : ({1'b0, a0} + {1'b0, b0});

    qthree_sweep_gen #(.HOLD_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .alu_out(alu0),
        .a(a0), .b(b0), .select(sel0), .vec_valid(vv0), .busy(busy0),
        .done(done0), .vec_count(cnt0), .checksum(sum0));

    // dut1: HOLD=1, defaults; stub a+b
    logic        start1 = 0, abort1 = 0;
    logic [4:0]  alu1;
    logic [3:0]  a1, b1;
    logic [2:0]  sel1;
    logic        vv1, busy1, done1;
    logic [11:0] cnt1;
    logic [15:0] sum1;
    assign alu1 = {1'b0, a1} + {1'b0, b1};

    qthree_sweep_gen #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .alu_out(alu1),
        .a(a1), .b(b1), .select(sel1), .vec_valid(vv1), .busy(busy1),
        .done(done1), .vec_count(cnt1), .checksum(sum1));

    // dut2: full operand range, HOLD=1; stub constant 31
    logic        start2 = 0, abort2 = 0;
    logic [4:0]  alu2;
    logic [3:0]  a2, b2;
    logic [2:0]  sel2;
    logic        vv2, busy2, done2;
    logic [11:0] cnt2;
    logic [15:0] sum2;
    assign alu2 = 5'd31;

    qthree_sweep_gen #(.HOLD_CYCLES(1), .A_FIRST(0), .A_LAST(15), .B_FIRST(0),
                       .B_LAST(15), .SEL_LAST(7)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .alu_out(alu2),
        .a(a2), .b(b2), .select(sel2), .vec_valid(vv2), .busy(busy2),
        .done(done2), .vec_count(cnt2), .checksum(sum2));

    logic seen_done0 = 0;
    always @(posedge clk) if (done0) seen_done0 <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_ab_sel"}, {21'd0, a0, b0, sel0}, 32'd0);
        chk({tag, "_flags"}, {29'd0, vv0, busy0, done0}, 32'd0);
        chk({tag, "_cnt"}, {20'd0, cnt0}, 32'd0);
        chk({tag, "_sum"}, {16'd0, sum0}, 32'd0);
    endtask

    initial begin
        int k;
        int exp_a, exp_b, exp_s;

        // ---- reset state
        repeat (2) @(negedge clk);
        chk_zero0("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ---- full sweep HOLD=2, a+b, with a start re-pulse mid-run
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("first_vec", {21'd0, a0, b0, sel0}, {21'd0, 4'd1, 4'd1, 3'd0});
        chk("run_flags", {29'd0, vv0, busy0, done0}, {29'd0, 3'b110});
        k = 0;
        while (!done0 && k < 400) begin
            @(negedge clk);
            k++;
            start0 = (k == 50);
        end
        start0 = 1'b0;
        chk("done_latency", k, 144);
        chk("sweep_cnt", {20'd0, cnt0}, 72);
        chk("sweep_sum", {16'd0, sum0}, 288);
        chk("done_flags", {29'd0, vv0, busy0, done0}, {29'd0, 3'b011});
        @(negedge clk);
        chk("after_done_flags", {29'd0, vv0, busy0, done0}, 32'd0);
        chk("final_vec_held", {21'd0, a0, b0, sel0}, {21'd0, 4'd3, 4'd3, 3'd7});

        // ---- start+abort together in IDLE: nothing happens
        start0 = 1'b1; abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; abort0 = 1'b0;
        @(negedge clk);
        chk("sa_busy", {31'd0, busy0}, 0);
        chk("sa_sum_kept", {16'd0, sum0}, 288);
        chk("sa_cnt_kept", {20'd0, cnt0}, 72);

        // ---- abort after the 10th sample, stub = 1
        mode0 = 1'b1;
        seen_done0 = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (k = 0; k < 20; k++) @(negedge clk);
        chk("pre_abort_cnt", {20'd0, cnt0}, 10);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort_flags", {29'd0, vv0, busy0, done0}, 32'd0);
        chk("abort_cnt", {20'd0, cnt0}, 10);
        chk("abort_sum", {16'd0, sum0}, 10);
        repeat (5) @(negedge clk);
        chk("abort_no_done", {31'd0, seen_done0}, 0);
        chk("abort_cnt_held", {20'd0, cnt0}, 10);

        // ---- asynchronous reset mid-run, then a full sweep
        mode0 = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero0("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while (!done0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("rerun_latency", k, 144);
        chk("rerun_cnt", {20'd0, cnt0}, 72);
        chk("rerun_sum", {16'd0, sum0}, 288);

        // ---- vector order, HOLD=1
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int v = 0; v < 72; v++) begin
            exp_s = v / 9;
            exp_a = 1 + (v % 9) / 3;
            exp_b = 1 + v % 3;
            chk($sformatf("order_v%0d", v), {20'd0, a1, b1, sel1, vv1},
                {20'd0, 4'(exp_a), 4'(exp_b), 3'(exp_s), 1'b1});
            @(negedge clk);
        end
        chk("order_end_flags", {29'd0, vv1, busy1, done1}, {29'd0, 3'b011});
        chk("order_cnt", {20'd0, cnt1}, 72);
        chk("order_sum", {16'd0, sum1}, 288);

        // ---- full range, stub 31, no checksum wrap
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (!done2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("full_latency", k, 2048);
        chk("full_cnt", {20'd0, cnt2}, 2048);
        chk("full_sum", {16'd0, sum2}, 63488);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
